// File: rtl/sd_bd_pkg.sv
// Shared encodings for the SD buffer-descriptor RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sd_bd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_TX  = 2'd1,
        ST_GNT_RX  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_TX = 1'b0,
        OWN_RX = 1'b1
    } owner_t;

    // Cycles of ram_re without ram_ack before a grant is abandoned.
    localparam logic [3:0] TO_LIMIT = 4'd15;

    // last_gnt reset value: pretending RX went last makes TX win the first tie.
    localparam owner_t LAST_GNT_RST = OWN_RX;

endpackage

// File: rtl/sd_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not served last.
// Latency: combinational.
// Backpressure: none; the caller decides whether a pick is used (no request -> pick is TX, ignored).
// Ports: req_a (TX request), req_b (RX request), last (previous owner) -> pick (chosen owner).
module sd_rr_pick2
    import sd_bd_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last,
    output owner_t pick
);

    always_comb begin
        pick = OWN_TX;
        if (req_a && req_b) begin
            pick = (last == OWN_TX) ? OWN_RX : OWN_TX;
        end else if (req_b) begin
            pick = OWN_RX;
        end
    end

endmodule

// File: rtl/sd_bd_arbiter.sv
// Arbitrates TX/RX descriptor-fetch masters onto one BD RAM read port in BURST-word grants.
// Latency: grant one cycle after request; RAM ack/data routed to the owner combinationally; one-cycle RELEASE turnaround.
// Backpressure: owner waits on ram_ack; non-owner held off until RELEASE->IDLE (optional timeout via SD_BD_ARB_TIMEOUT_EN).
// Ports: clk, rst_n; req_tx/ack_tx/dat_tx and req_rx/ack_rx/dat_rx master sides;
//        ram_re/ram_sel/ram_ack/ram_dat RAM side; gnt (one-hot {rx,tx}), word_cnt, err_to status.
module sd_bd_arbiter
    import sd_bd_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BURST = 2
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_tx,
    output logic          ack_tx,
    output logic [DW-1:0] dat_tx,
    input  logic          req_rx,
    output logic          ack_rx,
    output logic [DW-1:0] dat_rx,
    output logic          ram_re,
    output logic          ram_sel,
    input  logic          ram_ack,
    input  logic [DW-1:0] ram_dat,
    output logic [1:0]    gnt,
    output logic [2:0]    word_cnt,
    output logic          err_to
);

    localparam logic [2:0] BURST_W = 3'(BURST);

    state_t        r_state;
    state_t        w_state_nxt;
    owner_t        r_last_gnt;
    owner_t        w_pick;
    logic [2:0]    r_word_cnt;
    logic [DW-1:0] r_dat_tx;
    logic [DW-1:0] r_dat_rx;
    logic          w_to_hit;
    logic          w_in_gnt;
    logic          w_done;

    sd_rr_pick2 u_pick (
        .req_a (req_tx),
        .req_b (req_rx),
        .last  (r_last_gnt),
        .pick  (w_pick)
    );

    assign w_in_gnt = (r_state == ST_GNT_TX) || (r_state == ST_GNT_RX);

`ifdef SD_BD_ARB_TIMEOUT_EN
    logic [3:0] r_to_cnt;

    // Counts stalled read cycles; clears whenever the RAM answers or the read stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= 4'd0;
        end else if (ram_re && !ram_ack) begin
            r_to_cnt <= r_to_cnt + 4'd1;
        end else begin
            r_to_cnt <= 4'd0;
        end
    end

    assign w_to_hit = w_in_gnt && (r_to_cnt == TO_LIMIT);
`else
    assign w_to_hit = 1'b0;
`endif

    assign err_to   = w_to_hit;
    assign word_cnt = r_word_cnt;

    // Leave the grant on the ack that completes the burst so ram_re is already
    // low in the following cycle; also on request drop or timeout.
    assign w_done = w_to_hit
                 || (r_word_cnt >= BURST_W)
                 || (ram_ack && (r_word_cnt == BURST_W - 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_re      = 1'b0;
        ram_sel     = 1'b0;
        gnt         = 2'b00;
        ack_tx      = 1'b0;
        ack_rx      = 1'b0;
        dat_tx      = r_dat_tx;
        dat_rx      = r_dat_rx;
        case (r_state)
            ST_IDLE: begin
                if (req_tx || req_rx) begin
                    w_state_nxt = (w_pick == OWN_TX) ? ST_GNT_TX : ST_GNT_RX;
                end
            end
            ST_GNT_TX: begin
                gnt     = 2'b01;
                ram_sel = OWN_TX;
                ram_re  = req_tx && (r_word_cnt < BURST_W) && !w_to_hit;
                ack_tx  = ram_ack;
                dat_tx  = ram_dat;
                if (!req_tx || w_done) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_GNT_RX: begin
                gnt     = 2'b10;
                ram_sel = OWN_RX;
                ram_re  = req_rx && (r_word_cnt < BURST_W) && !w_to_hit;
                ack_rx  = ram_ack;
                dat_rx  = ram_dat;
                if (!req_rx || w_done) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= LAST_GNT_RST;
            r_word_cnt <= 3'd0;
            r_dat_tx   <= '0;
            r_dat_rx   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
                r_last_gnt <= w_pick;
            end
            // RELEASE always leads to IDLE, so clearing here means IDLE sees zero.
            if (r_state == ST_RELEASE) begin
                r_word_cnt <= 3'd0;
            end else if (w_in_gnt && ram_ack && (r_word_cnt < BURST_W)) begin
                r_word_cnt <= r_word_cnt + 3'd1;
            end
            // Non-owner data output presents the last word delivered to that master.
            if ((r_state == ST_GNT_TX) && ram_ack) begin
                r_dat_tx <= ram_dat;
            end
            if ((r_state == ST_GNT_RX) && ram_ack) begin
                r_dat_rx <= ram_dat;
            end
        end
    end

endmodule
